aes_key_repeater: RTL and testbench
===================================

Name: aes_key_repeater

Overview:
- Stream stage directly upstream of the AES engine's key sink (b_i).
- Accepts the 4-word AES-128 key once per job from a 32-bit key stream and stores it.
- Replays the key words cyclically (k0,k1,k2,k3,k0,...) for exactly len words.
- Effect: the engine sees key[i%4] alongside data word i, and the streamer/DMA fetches the key only once.

Parameters:
- DATA_WIDTH, 32, width of key stream words.
- KEY_WORDS, 4, words per key; must be a power of two.
- LEN_WIDTH, 11, width of the job length field; matches the engine ctrl len.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- clear_i  in  1  synchronous soft clear.
- start_i  in  1  single-cycle job start pulse.
- len_i  in  LEN_WIDTH  number of key words to emit; sampled on start_i.
- key_i_valid  in  1  key sink valid.
- key_i_data  in  DATA_WIDTH  key sink data.
- key_i_ready  out  1  key sink ready.
- key_o_valid  out  1  key source valid; feeds the engine b_i.
- key_o_data  out  DATA_WIDTH  key source data.
- key_o_ready  in  1  key source ready.
- busy_o  out  1  high whenever the state is not IDLE.
- done_o  out  1  one-cycle pulse at job end.

Behaviour:
- Reset (rst_ni=0, asynchronous) forces the following; these are also the values after clear_i:
  - state=IDLE, key registers=0, load index=0, emit index=0, remaining count=0.
  - All outputs 0: key_i_ready, key_o_valid, key_o_data, busy_o, done_o.
- FSM states: IDLE, LOAD, STREAM, DONE.
- IDLE:
  - start_i with len_i!=0: latch len into the remaining counter, go to LOAD.
  - start_i with len_i==0: go to DONE; no key consumed, nothing emitted.
  - start_i is ignored in every state other than IDLE.
- LOAD:
  - key_i_ready=1.
  - Each key_i_valid&key_i_ready beat writes key_q[load_idx]; load_idx increments.
  - The beat with load_idx==KEY_WORDS-1 moves to STREAM; load_idx wraps to 0.
  - key_o_valid=0 throughout LOAD.
- STREAM:
  - key_o_valid=1, key_o_data=key_q[emit_idx]; both are driven from registers, no combinational path from ready.
  - Valid and data stay stable until the handshake; valid never drops without a handshake.
  - On key_o_valid&key_o_ready: emit_idx increments mod KEY_WORDS and remaining decrements.
  - The handshake that brings remaining to 0 moves to DONE.
  - key_i_ready=0 throughout STREAM.
- DONE: done_o=1 for exactly one cycle, key_o_valid=0, then IDLE.
- Latency:
  - First key_o_valid rises the cycle after the 4th key word is accepted.
  - Sustained throughput is 1 word/cycle while ready is held high.
  - done_o asserts the cycle after the last output handshake.
- len_i not a multiple of 4 is legal; emission stops mid-key (e.g. len=6 emits k0..k3,k0,k1).
- len_i = 2^LEN_WIDTH-1 (2047) must count correctly without overflow.
- clear_i has priority over every other event in the same cycle, including start_i and in-flight handshakes:
  - Next cycle: IDLE, all indices/counters zeroed, key registers zeroed.
  - No done_o pulse.
- Extra key_i beats arriving outside LOAD are back-pressured (ready=0), never dropped.

Optional Feature:
- Macro: AES_KEY_REUSE_EN.
- When defined:
  - Adds input port reuse_key_i (1 bit, sampled with start_i) and an internal key_valid_q flag.
  - key_valid_q is set on LOAD completion and cleared by reset/clear_i.
  - start_i with reuse_key_i=1 and key_valid_q=1 goes IDLE->STREAM directly, skipping LOAD, with emit_idx=0.
  - If key_valid_q=0, reuse_key_i is ignored and LOAD runs.
- When undefined: no port, no flag; every job runs LOAD.

Decomposition:
- Shared package aes_package holds:
  - constants AES_KEY_WORDS=4 and AES_LEN_WIDTH=11;
  - typedef enum aes_key_rep_state_t {IDLE, LOAD, STREAM, DONE};
  - typedef aes_word_t = logic[31:0].
- No sub-module: indices and the remaining counter stay inline in one module.

Test Plan:
- Common stimulus: key 2b7e1516,28aed2a6,abf71588,09cf4f3c.
- Basic job: start, len=16, key stream as above, ready=1 -> key_o emits the 4 words 4 times in order over 16 consecutive cycles; done_o pulses once, the cycle after the 16th beat.
- Back-pressure: len=16, key_o_ready toggled on cycles k%7==0 or k%11==0 -> same 16-word sequence; data stable whenever valid&!ready; no drops or duplicates.
- Partial and zero length:
  - len=6 -> 2b7e1516,28aed2a6,abf71588,09cf4f3c,2b7e1516,28aed2a6, then done.
  - len=0 -> done_o the cycle after start, key_i_ready never asserted.
- Clear mid-stream: clear_i after the 5th output beat of len=16 -> next cycle key_o_valid=0, busy_o=0, no done_o; a new start reloads the key and the first output is 2b7e1516.
- Async reset mid-LOAD: rst_ni low after 2 key beats -> outputs 0 immediately; after release and a new start, 4 fresh beats are required before output.
- With AES_KEY_REUSE_EN: job 1 len=4, then job 2 start with reuse_key_i=1, len=8 -> no key_i_ready; output 2b7e1516..09cf4f3c twice.

Source files
------------

// File: rtl/aes_package.sv
// Shared AES stream-stage types: key geometry, job length width and key repeater FSM states.
package aes_package;

   localparam int AES_KEY_WORDS = 4;
   localparam int AES_LEN_WIDTH = 11;

   typedef logic [31:0] aes_word_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } aes_key_rep_state_t;

endpackage

// File: rtl/aes_key_repeater.sv
// Captures one AES key per job from the key stream and replays it cyclically for len words.
// Optional AES_KEY_REUSE_EN: reuse_key_i lets a job skip LOAD when a key is already held.
module aes_key_repeater
   import aes_package::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int KEY_WORDS  = AES_KEY_WORDS,
   parameter int LEN_WIDTH  = AES_LEN_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  start_i,
   input  logic [LEN_WIDTH-1:0]  len_i,
`ifdef AES_KEY_REUSE_EN
   input  logic                  reuse_key_i,
`endif
   input  logic                  key_i_valid,
   input  logic [DATA_WIDTH-1:0] key_i_data,
   output logic                  key_i_ready,
   output logic                  key_o_valid,
   output logic [DATA_WIDTH-1:0] key_o_data,
   input  logic                  key_o_ready,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int IDX_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_WORDS - 1);

   aes_key_rep_state_t state_q, state_d;

   logic [DATA_WIDTH-1:0] key_q [KEY_WORDS];
   logic [IDX_W-1:0]      load_idx_q, emit_idx_q;
   logic [LEN_WIDTH-1:0]  rem_q;

   logic in_hs, out_hs, load_last, stream_last, job_go, reuse_go;

   assign in_hs       = key_i_valid & key_i_ready;
   assign out_hs      = key_o_valid & key_o_ready;
   assign load_last   = in_hs && (load_idx_q == LAST_IDX);
   assign stream_last = out_hs && (rem_q == LEN_WIDTH'(1));
   assign job_go      = (state_q == IDLE) && start_i;

`ifdef AES_KEY_REUSE_EN
   logic key_valid_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)        key_valid_q <= 1'b0;
      else if (clear_i)   key_valid_q <= 1'b0;
      else if (load_last) key_valid_q <= 1'b1;
   end

   assign reuse_go = reuse_key_i & key_valid_q;
`else
   assign reuse_go = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               if (len_i == '0)   state_d = DONE;
               else if (reuse_go) state_d = STREAM;
               else               state_d = LOAD;
            end
         end
         LOAD:    if (load_last)   state_d = STREAM;
         STREAM:  if (stream_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Soft clear beats start and any handshake landing in the same cycle.
      if (clear_i) state_d = IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < KEY_WORDS; i++) key_q[i] <= '0;
         load_idx_q <= '0;
         emit_idx_q <= '0;
         rem_q      <= '0;
      end else if (clear_i) begin
         for (int i = 0; i < KEY_WORDS; i++) key_q[i] <= '0;
         load_idx_q <= '0;
         emit_idx_q <= '0;
         rem_q      <= '0;
      end else begin
         // Indices restart every job so a reused key always replays from word 0.
         if (job_go) begin
            rem_q      <= len_i;
            load_idx_q <= '0;
            emit_idx_q <= '0;
         end
         if (in_hs) begin
            key_q[load_idx_q] <= key_i_data;
            load_idx_q        <= load_idx_q + 1'b1;
         end
         if (out_hs) begin
            emit_idx_q <= emit_idx_q + 1'b1;
            rem_q      <= rem_q - 1'b1;
         end
      end
   end

   assign key_i_ready = (state_q == LOAD);
   assign key_o_valid = (state_q == STREAM);
   assign key_o_data  = key_o_valid ? key_q[emit_idx_q] : '0;
   assign busy_o      = (state_q != IDLE);
   assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_aes_key_repeater.sv
// Directed bench for aes_key_repeater: full, back-pressured, partial, zero, max-length, clear and reset jobs.
module tb_aes_key_repeater;
   import aes_package::*;

   logic            clk_i = 1'b0;
   logic            rst_ni = 1'b0;
   logic            clear_i = 1'b0;
   logic            start_i = 1'b0;
   logic [10:0]     len_i = '0;
`ifdef AES_KEY_REUSE_EN
   logic            reuse_key_i = 1'b0;
`endif
   logic            key_i_valid = 1'b0;
   aes_word_t       key_i_data = '0;
   logic            key_i_ready;
   logic            key_o_valid;
   aes_word_t       key_o_data;
   logic            key_o_ready = 1'b1;
   logic            busy_o;
   logic            done_o;

   aes_word_t key [4];
   int n_chk = 0;
   int n_pass = 0;

   aes_key_repeater dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clear_i     (clear_i),
      .start_i     (start_i),
      .len_i       (len_i),
`ifdef AES_KEY_REUSE_EN
      .reuse_key_i (reuse_key_i),
`endif
      .key_i_valid (key_i_valid),
      .key_i_data  (key_i_data),
      .key_i_ready (key_i_ready),
      .key_o_valid (key_o_valid),
      .key_o_data  (key_o_data),
      .key_o_ready (key_o_ready),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic start_job(input int len, input bit reuse);
      start_i = 1'b1;
      len_i   = 11'(len);
`ifdef AES_KEY_REUSE_EN
      reuse_key_i = reuse;
`else
      if (reuse) $display("reuse requested without AES_KEY_REUSE_EN");
`endif
      step();
      start_i = 1'b0;
`ifdef AES_KEY_REUSE_EN
      reuse_key_i = 1'b0;
`endif
   endtask

   task automatic load_key();
      for (int i = 0; i < 4; i++) begin
         key_i_valid = 1'b1;
         key_i_data  = key[i];
         chk("ld_ready", key_i_ready, 1);
         chk("ld_ovalid", key_o_valid, 0);
         step();
      end
      key_i_valid = 1'b0;
      key_i_data  = '0;
   endtask

   // Drives key_o_ready and scores every output handshake against key[idx%4].
   task automatic stream(input int len, input bit bp, input int stop_after, output int cycles);
      int idx = 0;
      int k = 0;
      bit stall = 0;
      aes_word_t held = '0;
      while (idx < len && k < 5000) begin
         key_o_ready = bp ? !((k % 7 == 0) || (k % 11 == 0)) : 1'b1;
         chk("o_valid", key_o_valid, 1);
         chk("i_ready_stream", key_i_ready, 0);
         if (stall) chk("o_stable", key_o_data, held);
         if (key_o_ready) begin
            chk("o_data", key_o_data, key[idx % 4]);
            idx++;
            stall = 0;
         end else begin
            stall = 1;
            held  = key_o_data;
         end
         step();
         k++;
         if (stop_after > 0 && idx == stop_after) break;
      end
      if (k >= 5000) chk("stream_timeout", 0, 1);
      cycles = k;
   endtask

   task automatic check_done();
      chk("done_pulse", done_o, 1);
      chk("done_ovalid", key_o_valid, 0);
      chk("done_busy", busy_o, 1);
      step();
      chk("done_drop", done_o, 0);
      chk("idle_busy", busy_o, 0);
   endtask

   initial begin
      int cyc;
      key[0] = 32'h2b7e1516;
      key[1] = 32'h28aed2a6;
      key[2] = 32'habf71588;
      key[3] = 32'h09cf4f3c;

      #22 rst_ni = 1'b1;
      step();
      chk("rst_iready", key_i_ready, 0);
      chk("rst_ovalid", key_o_valid, 0);
      chk("rst_odata", key_o_data, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);

      // Basic job, 16 words back to back.
      start_job(16, 0);
      load_key();
      stream(16, 0, 0, cyc);
      chk("basic_cycles", cyc, 16);
      check_done();

      // Back-pressure on the output side.
      start_job(16, 0);
      load_key();
      stream(16, 1, 0, cyc);
      check_done();

      // Partial length stops mid-key.
      start_job(6, 0);
      load_key();
      stream(6, 0, 0, cyc);
      chk("len6_cycles", cyc, 6);
      check_done();

      // Zero length: straight to DONE without touching the key stream.
      key_i_valid = 1'b1;
      key_i_data  = 32'hdeadbeef;
      start_job(0, 0);
      chk("len0_iready", key_i_ready, 0);
      check_done();
      chk("len0_iready_idle", key_i_ready, 0);
      key_i_valid = 1'b0;

      // Maximum length must count down from 2047 without wrapping.
      start_job(2047, 0);
      load_key();
      stream(2047, 0, 0, cyc);
      chk("max_cycles", cyc, 2047);
      check_done();

      // Clear after the 5th output beat, with a handshake pending the same cycle.
      start_job(16, 0);
      load_key();
      stream(16, 0, 5, cyc);
      clear_i     = 1'b1;
      key_o_ready = 1'b1;
      step();
      clear_i = 1'b0;
      chk("clr_ovalid", key_o_valid, 0);
      chk("clr_odata", key_o_data, 0);
      chk("clr_busy", busy_o, 0);
      chk("clr_done", done_o, 0);
      step();
      chk("clr_done2", done_o, 0);
      start_job(4, 0);
      load_key();
      stream(4, 0, 0, cyc);
      check_done();

      // Async reset after two key beats.
      start_job(8, 0);
      for (int i = 0; i < 2; i++) begin
         key_i_valid = 1'b1;
         key_i_data  = key[i];
         step();
      end
      key_i_valid = 1'b0;
      #2 rst_ni = 1'b0;
      #1;
      chk("arst_iready", key_i_ready, 0);
      chk("arst_busy", busy_o, 0);
      chk("arst_ovalid", key_o_valid, 0);
      chk("arst_done", done_o, 0);
      #2 rst_ni = 1'b1;
      step();
      start_job(4, 0);
      load_key();
      stream(4, 0, 0, cyc);
      check_done();

`ifdef AES_KEY_REUSE_EN
      start_job(4, 0);
      load_key();
      stream(4, 0, 0, cyc);
      check_done();
      start_job(8, 1);
      chk("reuse_iready", key_i_ready, 0);
      stream(8, 0, 0, cyc);
      chk("reuse_cycles", cyc, 8);
      check_done();
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
